// File: rtl/tb_pkg.sv
// Shared definitions for the simulation test-completion monitor: FSM states,
// default snooped register indices and the magic "true" register value.
package tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SETTLE,
    REPORT,
    TIMEOUT
  } state_t;

  localparam int unsigned DEF_DONE_REG = 26;
  localparam int unsigned DEF_PASS_REG = 27;
  localparam int unsigned DEF_TNUM_REG = 3;
  localparam int unsigned MAGIC_VAL    = 1;

endpackage

// File: rtl/tb_hart_shadow.sv
// Per-hart shadow copies of the done, pass and test-number registers,
// captured by snooping that hart's register-file write port.
module tb_hart_shadow
  import tb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DONE_REG   = DEF_DONE_REG,
  parameter int unsigned PASS_REG   = DEF_PASS_REG,
  parameter int unsigned TNUM_REG   = DEF_TNUM_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_en,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  output logic                  done_flag,
  output logic                  pass_flag,
  output logic [XLEN-1:0]       tnum
);

  logic [XLEN-1:0] done_q;
  logic [XLEN-1:0] pass_q;
  logic [XLEN-1:0] tnum_q;
  logic            wr;

  // x0 is hardwired to zero in the hart, so writes to it never reach a shadow
  always_comb begin
    wr = upd_en && we && (waddr != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= '0;
      pass_q <= '0;
      tnum_q <= '0;
    end else if (wr) begin
      if (waddr == REG_ADDR_W'(DONE_REG)) done_q <= wdata;
      if (waddr == REG_ADDR_W'(PASS_REG)) pass_q <= wdata;
      if (waddr == REG_ADDR_W'(TNUM_REG)) tnum_q <= wdata;
    end
  end

  always_comb begin
    done_flag = (done_q == XLEN'(MAGIC_VAL));
    pass_flag = (pass_q == XLEN'(MAGIC_VAL));
    tnum      = tnum_q;
  end

endmodule

// File: rtl/tb_test_monitor.sv
// Multi-hart test-completion monitor: waits for every hart to flag done,
// lets late writes settle, then latches a sticky pass/fail verdict or a timeout.
module tb_test_monitor
  import tb_pkg::*;
#(
  parameter int unsigned NUM_HARTS     = 1,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned DONE_REG      = DEF_DONE_REG,
  parameter int unsigned PASS_REG      = DEF_PASS_REG,
  parameter int unsigned TNUM_REG      = DEF_TNUM_REG,
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned TIMEOUT_W     = 21,
  parameter int unsigned TIMEOUT_EN    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable_i,
  input  logic [NUM_HARTS-1:0]            we_i,
  input  logic [NUM_HARTS*REG_ADDR_W-1:0] waddr_i,
  input  logic [NUM_HARTS*XLEN-1:0]       wdata_i,
  output logic                            done_o,
  output logic                            pass_o,
  output logic                            fail_o,
  output logic                            timeout_o,
  output logic [$clog2(NUM_HARTS):0]      fail_hart_o,
  output logic [XLEN-1:0]                 fail_testnum_o,
  output logic [TIMEOUT_W-1:0]            cycle_count_o
);

  localparam int unsigned FHW = $clog2(NUM_HARTS) + 1;
  localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);

  state_t           state, state_nx;
  logic [NUM_HARTS-1:0] done_v, pass_v;
  logic [XLEN-1:0]  tnum_v [NUM_HARTS];
  logic             upd_en, all_done, timeout_hit, settle_last;
  logic [TIMEOUT_W-1:0] cycle_count;
  logic [SCW-1:0]   settle_cnt;
  logic             pass_q, fail_q;
  logic [FHW-1:0]   fail_hart_q, fail_idx;
  logic [XLEN-1:0]  fail_tnum_q, fail_tnum;
  logic             found;

  // Shadows keep tracking through SETTLE so late pass writes are still seen
  always_comb begin
    upd_en = (state != REPORT) && (state != TIMEOUT);
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    tb_hart_shadow #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W),
      .DONE_REG   (DONE_REG),
      .PASS_REG   (PASS_REG),
      .TNUM_REG   (TNUM_REG)
    ) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .upd_en    (upd_en),
      .we        (we_i[h]),
      .waddr     (waddr_i[h*REG_ADDR_W +: REG_ADDR_W]),
      .wdata     (wdata_i[h*XLEN +: XLEN]),
      .done_flag (done_v[h]),
      .pass_flag (pass_v[h]),
      .tnum      (tnum_v[h])
    );
  end

  always_comb begin
    all_done    = &done_v;
    timeout_hit = (TIMEOUT_EN != 0) && cycle_count[TIMEOUT_W-1];
    settle_last = (settle_cnt == SCW'(SETTLE_CYCLES - 1));
    found       = 1'b0;
    fail_idx    = '0;
    fail_tnum   = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (!found && !pass_v[h]) begin
        found     = 1'b1;
        fail_idx  = FHW'(h);
        fail_tnum = tnum_v[h];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // all_done is tested before the timeout so a coincident final done wins
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable_i) state_nx = RUN;
      RUN: begin
        if (all_done)         state_nx = SETTLE;
        else if (timeout_hit) state_nx = TIMEOUT;
      end
      SETTLE:  if (settle_last) state_nx = REPORT;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      settle_cnt  <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_hart_q <= '0;
      fail_tnum_q <= '0;
    end else begin
      if (state == RUN) cycle_count <= cycle_count + 1'b1;
      if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                 settle_cnt <= '0;
      if (state == SETTLE && settle_last) begin
        pass_q      <= !found;
        fail_q      <= found;
        fail_hart_q <= fail_idx;
        fail_tnum_q <= fail_tnum;
      end
    end
  end

  always_comb begin
    done_o         = (state == REPORT);
    timeout_o      = (state == TIMEOUT);
    pass_o         = pass_q;
    fail_o         = fail_q;
    fail_hart_o    = fail_hart_q;
    fail_testnum_o = fail_tnum_q;
    cycle_count_o  = cycle_count;
  end

endmodule

// File: tb/tb_tb_test_monitor.sv
// Self-checking bench for tb_test_monitor: directed single-hart runs plus
// randomized two-hart write schedules checked against a schedule-level model.
module tb_tb_test_monitor;

  localparam int H    = 2;
  localparam int S2   = 3;
  localparam int W2   = 6;
  localparam int TO_K = (1 << (W2 - 1)) + 1;
  localparam int L    = 48;
  localparam int OBS  = 80;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en1 = 1'b0, we1 = 1'b0;
  logic [4:0]  wa1 = '0;
  logic [31:0] wd1 = '0;
  logic        done1, pass1, fail1, to1;
  logic [0:0]  fh1;
  logic [31:0] ft1;
  logic [20:0] cc1;

  logic          en2 = 1'b0;
  logic [H-1:0]  we2 = '0;
  logic [H*5-1:0]  wa2 = '0;
  logic [H*32-1:0] wd2 = '0;
  logic        done2, pass2, fail2, to2, done3, pass3, fail3, to3;
  logic [1:0]  fh2, fh3;
  logic [31:0] ft2, ft3;
  logic [5:0]  cc2, cc3;

  tb_test_monitor #(.NUM_HARTS(1)) u1 (
    .clk(clk), .rst(rst), .enable_i(en1), .we_i(we1), .waddr_i(wa1), .wdata_i(wd1),
    .done_o(done1), .pass_o(pass1), .fail_o(fail1), .timeout_o(to1),
    .fail_hart_o(fh1), .fail_testnum_o(ft1), .cycle_count_o(cc1));

  tb_test_monitor #(.NUM_HARTS(H), .SETTLE_CYCLES(S2), .TIMEOUT_W(W2), .TIMEOUT_EN(1)) u2 (
    .clk(clk), .rst(rst), .enable_i(en2), .we_i(we2), .waddr_i(wa2), .wdata_i(wd2),
    .done_o(done2), .pass_o(pass2), .fail_o(fail2), .timeout_o(to2),
    .fail_hart_o(fh2), .fail_testnum_o(ft2), .cycle_count_o(cc2));

  tb_test_monitor #(.NUM_HARTS(H), .SETTLE_CYCLES(S2), .TIMEOUT_W(W2), .TIMEOUT_EN(0)) u3 (
    .clk(clk), .rst(rst), .enable_i(en2), .we_i(we2), .waddr_i(wa2), .wdata_i(wd2),
    .done_o(done3), .pass_o(pass3), .fail_o(fail3), .timeout_o(to3),
    .fail_hart_o(fh3), .fail_testnum_o(ft3), .cycle_count_o(cc3));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write schedule for the two-hart instances: entry k is sampled k edges after RUN entry
  logic        sch_we [0:L][0:H-1];
  logic [4:0]  sch_a  [0:L][0:H-1];
  logic [31:0] sch_d  [0:L][0:H-1];

  typedef struct {
    int          d;
    bit          settle;
    bit          pass;
    int          fh;
    logic [31:0] ft;
  } exp_t;

  task automatic clear_sched();
    for (int k = 0; k <= L; k++)
      for (int h = 0; h < H; h++) begin
        sch_we[k][h] = 1'b0; sch_a[k][h] = '0; sch_d[k][h] = '0;
      end
  endtask

  task automatic set_w(input int k, input int h, input int a, input logic [31:0] d);
    sch_we[k][h] = 1'b1; sch_a[k][h] = 5'(a); sch_d[k][h] = d;
  endtask

  task automatic gen(input int dt, input bit allow26);
    int r, a;
    logic [31:0] d;
    clear_sched();
    for (int k = 1; k <= L; k++)
      for (int h = 0; h < H; h++)
        if ($urandom % 3 == 0) begin
          r = int'($urandom % 6);
          case (r)
            0: a = 0;
            1: a = 3;
            3: a = allow26 ? 26 : 27;
            4: begin a = int'($urandom % 32); if (!allow26 && a == 26) a = 25; end
            default: a = 27;
          endcase
          r = int'($urandom % 4);
          d = (r == 0) ? 32'd0 : (r == 3) ? 32'($urandom % 16) : 32'd1;
          set_w(k, h, a, d);
        end
    if (dt > 0) begin
      for (int h = 0; h < H; h++) begin
        if (dt > 2) set_w(dt - 2, h, 3, 32'($urandom % 100));
        if (dt > 1) set_w(dt - 1, h, 27, ($urandom % 4 != 0) ? 32'd1 : 32'd0);
        set_w(dt, h, 26, 32'd1);
      end
    end
  endtask

  // Replays the schedule on plain arrays: first all-done point, then verdict after settling
  function automatic exp_t model(input bit ten);
    exp_t e;
    logic [31:0] dn [H];
    logic [31:0] ps [H];
    logic [31:0] tn [H];
    bit ad;
    e.d = -1; e.settle = 0; e.pass = 0; e.fh = 0; e.ft = '0;
    for (int h = 0; h < H; h++) begin dn[h] = '0; ps[h] = '0; tn[h] = '0; end
    for (int k = 1; k <= L; k++) begin
      if (e.d >= 0 && k > e.d + S2) break;
      for (int h = 0; h < H; h++)
        if (sch_we[k][h]) begin
          if (sch_a[k][h] == 5'd26) dn[h] = sch_d[k][h];
          if (sch_a[k][h] == 5'd27) ps[h] = sch_d[k][h];
          if (sch_a[k][h] == 5'd3)  tn[h] = sch_d[k][h];
        end
      if (e.d < 0) begin
        ad = 1;
        for (int h = 0; h < H; h++) if (dn[h] != 32'd1) ad = 0;
        if (ad) e.d = k;
      end
    end
    e.settle = (e.d >= 0) && (!ten || e.d + 1 <= TO_K);
    e.pass = 1;
    for (int h = 0; h < H; h++)
      if (e.pass && ps[h] != 32'd1) begin e.pass = 0; e.fh = h; e.ft = tn[h]; end
    return e;
  endfunction

  task automatic check_inst(input string nm, input exp_t e, input bit ten, input int k,
                            input logic dn, input logic ps, input logic fl, input logic to,
                            input logic [1:0] fh, input logic [31:0] ft, input logic [5:0] cc);
    bit x_done, x_to;
    int x_cc;
    if (e.settle) begin
      x_done = (k >= e.d + 1 + S2); x_to = 0; x_cc = (k < e.d + 1) ? k : e.d + 1;
    end else if (ten) begin
      x_done = 0; x_to = (k >= TO_K); x_cc = (k < TO_K) ? k : TO_K;
    end else begin
      x_done = 0; x_to = 0; x_cc = k % 64;
    end
    check_eq($sformatf("%s done k=%0d", nm, k), dn, x_done);
    check_eq($sformatf("%s timeout k=%0d", nm, k), to, x_to);
    check_eq($sformatf("%s cycles k=%0d", nm, k), cc, x_cc);
    check_eq($sformatf("%s pass k=%0d", nm, k), ps, x_done && e.pass);
    check_eq($sformatf("%s fail k=%0d", nm, k), fl, x_done && !e.pass);
    check_eq($sformatf("%s fail_hart k=%0d", nm, k), fh, (x_done && !e.pass) ? e.fh : 0);
    check_eq($sformatf("%s fail_tnum k=%0d", nm, k), ft, (x_done && !e.pass) ? e.ft : 0);
  endtask

  task automatic run(input bit do_reset, input int abort_k);
    exp_t e2, e3;
    e2 = model(1'b1);
    e3 = model(1'b0);
    we2 = '0;
    if (do_reset) begin
      rst = 1'b1; #2; rst = 1'b0;
      check_eq("reset u2 done", done2, 0);
      check_eq("reset u2 cycles", cc2, 0);
      check_eq("reset u3 fail", fail3, 0);
    end
    en2 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0;
    for (int k = 0; k <= OBS; k++) begin
      check_inst("u2", e2, 1'b1, k, done2, pass2, fail2, to2, fh2, ft2, cc2);
      check_inst("u3", e3, 1'b0, k, done3, pass3, fail3, to3, fh3, ft3, cc3);
      if (k == abort_k) begin
        rst = 1'b1; #1;
        check_eq("abort done", done2, 0);
        check_eq("abort cycles", cc2, 0);
        check_eq("abort timeout", to2, 0);
        rst = 1'b0;
        return;
      end
      for (int h = 0; h < H; h++) begin
        we2[h]           = (k + 1 <= L) ? sch_we[k+1][h] : 1'b0;
        wa2[h*5 +: 5]    = (k + 1 <= L) ? sch_a[k+1][h] : 5'd0;
        wd2[h*32 +: 32]  = (k + 1 <= L) ? sch_d[k+1][h] : 32'd0;
      end
      @(posedge clk); #1;
    end
    we2 = '0;
  endtask

  task automatic u1_write(input int a, input int d);
    we1 = 1'b1; wa1 = 5'(a); wd1 = 32'(d);
    @(posedge clk); #1;
    we1 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    // Single hart pass: verdict on the 12th edge counting the one sampling x26
    rst = 1'b1; #2; rst = 1'b0;
    check_eq("u1 reset done", done1, 0);
    check_eq("u1 reset pass", pass1, 0);
    check_eq("u1 reset cycles", cc1, 0);
    en1 = 1'b1; @(posedge clk); #1; en1 = 1'b0;
    u1_write(27, 1);
    we1 = 1'b1; wa1 = 5'd26; wd1 = 32'd1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      we1 = 1'b0;
      if (n == 11) check_eq("u1 done early", done1, 0);
    end
    check_eq("u1 done", done1, 1);
    check_eq("u1 pass", pass1, 1);
    check_eq("u1 fail", fail1, 0);
    check_eq("u1 cycles", cc1, 3);

    // Single hart fail with test number 5
    rst = 1'b1; #2; rst = 1'b0;
    check_eq("u1 rerst done", done1, 0);
    en1 = 1'b1; @(posedge clk); #1; en1 = 1'b0;
    u1_write(3, 5);
    u1_write(27, 0);
    u1_write(26, 1);
    for (int i = 0; i < 20 && !done1; i++) begin @(posedge clk); #1; end
    check_eq("u1f done", done1, 1);
    check_eq("u1f fail", fail1, 1);
    check_eq("u1f pass", pass1, 0);
    check_eq("u1f hart", fh1, 0);
    check_eq("u1f tnum", ft1, 5);
    check_eq("u1f timeout", to1, 0);

    for (int i = 0; i < 6; i++) begin
      gen(int'($urandom_range(3, 20)), 1'b1);
      run(1'b1, -1);
    end

    // No done at all: u2 times out, u3 keeps counting and wraps
    gen(0, 1'b0);
    run(1'b1, -1);
    check_eq("to u2 timeout", to2, 1);
    check_eq("to u2 done", done2, 0);
    check_eq("to u3 timeout", to3, 0);

    // Final done sampled with the timeout bit already set: SETTLE wins
    gen(32, 1'b0);
    run(1'b1, -1);
    check_eq("tie u2 timeout", to2, 0);
    check_eq("tie u2 done", done2, 1);
    gen(33, 1'b0);
    run(1'b1, -1);
    check_eq("late u2 timeout", to2, 1);
    check_eq("late u3 done", done3, 1);

    // Hart1 fails; hart0 pass arrives during SETTLE and must count
    clear_sched();
    set_w(1, 0, 3, 4); set_w(1, 1, 3, 9);
    set_w(2, 1, 27, 0);
    set_w(3, 0, 26, 1); set_w(3, 1, 26, 1);
    set_w(5, 0, 27, 1);
    run(1'b1, -1);
    check_eq("h1 fail", fail2, 1);
    check_eq("h1 hart", fh2, 1);
    check_eq("h1 tnum", ft2, 9);

    // Reset in SETTLE, then a fresh run without any further reset
    run(1'b1, 5);
    clear_sched();
    set_w(1, 0, 27, 1); set_w(1, 1, 27, 1);
    set_w(2, 0, 26, 1); set_w(2, 1, 26, 1);
    run(1'b0, -1);
    check_eq("rerun pass", pass2, 1);
    check_eq("rerun fail", fail2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tb_test_monitor.md
# tb_test_monitor

Parametrised, synthesizable test-completion monitor for the simulation top. It snoops the register-file write ports of one or more harts and tracks the done, pass and test-number registers. After all harts signal done it waits a fixed number of settle cycles, then issues a sticky pass/fail verdict; a cycle-count timeout is also detected. It replaces hierarchical register peeks and the delay-based check with a clocked, multi-hart, port-driven checker the bench polls to print results and `$finish`.

## Interface
- NUM_HARTS, 1: number of snooped harts (1..8)
- XLEN, 32: register data width
- REG_ADDR_W, 5: register index width
- DONE_REG, 26: index whose value 1 marks test end
- PASS_REG, 27: index whose value 1 marks pass
- TNUM_REG, 3: index holding the current test number
- SETTLE_CYCLES, 10: cycles between all-done and verdict (≥1)
- TIMEOUT_W, 21: timeout fires when cycle count bit TIMEOUT_W-1 sets (2^20 cycles)
- TIMEOUT_EN, 1: 0 disables timeout (JTAG/debug runs)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable_i  in  1  start monitoring (level; sampled in IDLE only)
- we_i  in  NUM_HARTS  per-hart regfile write enable
- waddr_i  in  NUM_HARTS*REG_ADDR_W  per-hart write index, hart h at [h*REG_ADDR_W +: REG_ADDR_W]
- wdata_i  in  NUM_HARTS*XLEN  per-hart write data
- done_o  out  1  verdict available (sticky)
- pass_o  out  1  all harts passed (valid when done_o)
- fail_o  out  1  at least one hart failed (valid when done_o)
- timeout_o  out  1  timeout occurred (sticky; done_o stays 0)
- fail_hart_o  out  $clog2(NUM_HARTS)+1  lowest failing hart index
- fail_testnum_o  out  XLEN  TNUM shadow of that hart
- cycle_count_o  out  TIMEOUT_W  cycles spent in RUN

## Operation
- Per hart: three XLEN shadow registers (done, pass, tnum), reset 0; updated when we_i[h] and waddr matches; writes to index 0 ignored.
- Shadows update in every state except terminal ones (captures late pass writes during SETTLE).
- all_done = AND over harts of (done_shadow == 1).
- FSM: IDLE -> RUN when enable_i. RUN -> SETTLE when all_done. RUN -> TIMEOUT when TIMEOUT_EN and cycle_count[TIMEOUT_W-1]. SETTLE counts SETTLE_CYCLES, then -> REPORT. REPORT, TIMEOUT terminal until rst.
- all_done and timeout in same cycle: SETTLE wins; timeout never checked in SETTLE.
- Verdict, latched on SETTLE->REPORT: pass iff every hart pass_shadow == 1; else fail_o=1, fail_hart_o = lowest h with pass_shadow != 1, fail_testnum_o = its tnum_shadow. Done shadows not rechecked in SETTLE.
- cycle_count increments only in RUN; frozen elsewhere; no wrap (timeout fires first when enabled; with TIMEOUT_EN=0 it wraps modulo 2^TIMEOUT_W).
- enable_i deassertion after IDLE ignored.

## Timing
- Reset: all outputs 0, FSM IDLE, shadows 0, counters 0.
- Shadow valid one cycle after sampled write; FSM enters SETTLE on next edge; done_o rises SETTLE_CYCLES edges after entering SETTLE (total SETTLE_CYCLES+2 edges after final done write sampled).
- pass_o/fail_o/fail_* change on the same edge as done_o; stable thereafter.
- timeout_o rises on the edge after cycle_count bit TIMEOUT_W-1 sets.
- rst mid-operation: immediate return to reset state, all shadows cleared.

## Structure
- Shared package tb_pkg: FSM state enum (IDLE, RUN, SETTLE, REPORT, TIMEOUT), default register indices, magic value 1.
- One sub-module: tb_hart_shadow (per-hart shadow registers, emits done/pass flags and tnum), generated NUM_HARTS times.

## Test plan
- 1 hart: write x27=1, then x26=1, SETTLE_CYCLES=10 -> done_o=1, pass_o=1 exactly 12 edges after x26 write.
- 1 hart: x3=5, x27=0, x26=1 -> fail_o=1, fail_hart_o=0, fail_testnum_o=5.
- 2 harts: both done; hart1 x27=0, x3=9 -> fail_hart_o=1, fail_testnum_o=9; pass written during SETTLE on hart0 still counted.
- TIMEOUT_W=6, no done write -> timeout_o=1 after 32 RUN cycles, done_o stays 0; TIMEOUT_EN=0 -> no timeout.
- Final done write coinciding with timeout bit -> SETTLE taken, timeout_o=0, verdict issued.
- rst asserted during SETTLE -> outputs 0, FSM IDLE; rerun with enable_i -> correct fresh verdict.
